// File: rtl/cp_micropipeline.sv
// cp_micropipeline: clocked model of a 2-phase bundled-data micropipeline.
// A chain of DEPTH capture/pass stages, each governed by a C-element phase
// bit, with occupancy reporting, optional input synchronisers and a sticky
// producer protocol-violation flag.
module cp_micropipeline #(
  parameter int DATA_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 0,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_req,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ack,
  output logic                  out_req,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ack,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  proto_err
);

  logic                  rq;
  logic                  ak;
  logic                  rq_prev;
  logic [DEPTH-1:0]      c;
  logic [DEPTH-1:0]      up;
  logic [DEPTH-1:0]      dn;
  logic [DEPTH-1:0]      fire;
  logic [DEPTH-1:0]      full_v;
  logic [DATA_WIDTH-1:0] d [DEPTH];
  logic [CNT_W-1:0]      count_v;
  logic                  viol;

  // ---- input synchronisers ----
  if (SYNC_STAGES == 0) begin : g_nosync
    assign rq = in_req;
    assign ak = out_ack;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] rq_sync_p0;
    logic [SYNC_STAGES-1:0] ak_sync_p0;

    // Shift the raw handshake inputs through a reset-to-zero flop chain.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rq_sync_p0 <= '0;
        ak_sync_p0 <= '0;
      end else begin
        rq_sync_p0[0] <= in_req;
        ak_sync_p0[0] <= out_ack;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          rq_sync_p0[k] <= rq_sync_p0[k-1];
          ak_sync_p0[k] <= ak_sync_p0[k-1];
        end
      end
    end

    assign rq = rq_sync_p0[SYNC_STAGES-1];
    assign ak = ak_sync_p0[SYNC_STAGES-1];
  end

  // ---- C-element stage evaluation ----
  // Neighbour phases: stage 0 listens to the producer, the last stage to the
  // consumer. A stage fires when upstream offers a new phase and downstream
  // has already taken the previous one, so neighbours never fire together.
  assign up     = {c[DEPTH-2:0], rq};
  assign dn     = {ak, c[DEPTH-1:1]};
  assign fire   = (up ^ c) & ~(dn ^ c);
  assign full_v = c ^ dn;

  // Phase bits follow their upstream neighbour whenever the stage fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c <= '0;
    end else begin
      c <= (c & ~fire) | (up & fire);
    end
  end

  // Data latches capture from upstream on the same fire condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      if (fire[0]) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (fire[i]) d[i] <= d[i-1];
      end
    end
  end

  // ---- protocol check ----
  // A new producer toggle while the previous one is still unacknowledged.
  assign viol = (rq != rq_prev) && (rq_prev != c[0]);

  // Track the previous request phase and latch any violation until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rq_prev   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rq_prev <= rq;
      if (viol) proto_err <= 1'b1;
    end
  end

  // ---- occupancy ----
  // Population count of stages holding a token not yet taken downstream.
  always_comb begin
    count_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_v = count_v + CNT_W'(full_v[i]);
    end
  end

  assign count    = count_v;
  assign full     = (count_v == CNT_W'(DEPTH));
  assign empty    = (count_v == '0);
  assign in_ack   = c[0];
  assign out_req  = c[DEPTH-1];
  assign out_data = d[DEPTH-1];

endmodule

// File: tb/tb_cp_micropipeline.sv
// Directed self-checking bench for cp_micropipeline: one instance without
// synchronisers (DEPTH=4) and one with two synchroniser flops.
module tb_cp_micropipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance without synchronisers
  logic       rst_n1, in_req1, in_ack1, out_req1, out_ack1, full1, empty1, perr1;
  logic [2:0] in_data1, out_data1, count1;
  // Instance with SYNC_STAGES = 2
  logic       rst_n2, in_req2, in_ack2, out_req2, out_ack2, full2, empty2, perr2;
  logic [2:0] in_data2, out_data2, count2;

  cp_micropipeline #(.DATA_WIDTH(3), .DEPTH(4), .SYNC_STAGES(0)) dut1 (
    .clk(clk), .rst_n(rst_n1), .in_req(in_req1), .in_data(in_data1),
    .in_ack(in_ack1), .out_req(out_req1), .out_data(out_data1),
    .out_ack(out_ack1), .count(count1), .full(full1), .empty(empty1),
    .proto_err(perr1)
  );

  cp_micropipeline #(.DATA_WIDTH(3), .DEPTH(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .in_req(in_req2), .in_data(in_data2),
    .in_ack(in_ack2), .out_req(out_req2), .out_data(out_data2),
    .out_ack(out_ack2), .count(count2), .full(full2), .empty(empty2),
    .proto_err(perr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Producer on instance 1: wait for the previous ack, then offer a token.
  task automatic send1(input logic [2:0] v);
    int n = 0;
    while (in_ack1 !== in_req1 && n < 50) begin
      tick(1);
      n++;
    end
    check("send1_ack_wait", 32'(in_ack1 === in_req1), 1);
    in_data1 = v;
    in_req1  = ~in_req1;
    tick(1);
  endtask

  task automatic send2(input logic [2:0] v);
    int n = 0;
    while (in_ack2 !== in_req2 && n < 50) begin
      tick(1);
      n++;
    end
    check("send2_ack_wait", 32'(in_ack2 === in_req2), 1);
    in_data2 = v;
    in_req2  = ~in_req2;
    tick(1);
  endtask

  // Consumer on instance 1: wait for a pending token, check it, take it.
  task automatic take1(input logic [2:0] exp);
    int n = 0;
    while (out_req1 === out_ack1 && n < 50) begin
      tick(1);
      n++;
    end
    check("drain_req_wait", 32'(out_req1 !== out_ack1), 1);
    check("drain_data", 32'(out_data1), 32'(exp));
    out_ack1 = ~out_ack1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n1 = 1'b0; in_req1 = 1'b1; in_data1 = 3'b111; out_ack1 = 1'b0;
    rst_n2 = 1'b0; in_req2 = 1'b0; in_data2 = 3'b000; out_ack2 = 1'b0;

    // Reset held two cycles with in_req high
    tick(2);
    check("rst_in_ack",   32'(in_ack1),   0);
    check("rst_out_req",  32'(out_req1),  0);
    check("rst_out_data", 32'(out_data1), 0);
    check("rst_count",    32'(count1),    0);
    check("rst_empty",    32'(empty1),    1);
    check("rst_full",     32'(full1),     0);
    check("rst_perr",     32'(perr1),     0);
    in_req1 = 1'b0;
    tick(1);
    rst_n1 = 1'b1;
    rst_n2 = 1'b1;
    tick(1);

    // Single token: ack after edge t, out_req after edge t+3
    in_data1 = 3'b101;
    in_req1  = 1'b1;
    tick(1);
    check("tok_ack_t",     32'(in_ack1),  1);
    check("tok_oreq_t",    32'(out_req1), 0);
    check("tok_count_t",   32'(count1),   1);
    tick(2);
    check("tok_oreq_t2",   32'(out_req1), 0);
    tick(1);
    check("tok_oreq_t3",   32'(out_req1),  1);
    check("tok_data_t3",   32'(out_data1), 5);
    check("tok_count_t3",  32'(count1),    1);
    out_ack1 = 1'b1;
    tick(1);
    check("tok_count_done", 32'(count1), 0);
    check("tok_empty_done", 32'(empty1), 1);

    // Fill with out_ack held, then a 5th offer must stall
    send1(3'd1);
    send1(3'd2);
    send1(3'd3);
    send1(3'd4);
    tick(6);
    check("fill_count", 32'(count1), 4);
    check("fill_full",  32'(full1),  1);
    check("fill_empty", 32'(empty1), 0);
    send1(3'd5);
    tick(20);
    check("stall_in_ack", 32'(in_ack1), 1);
    check("stall_count",  32'(count1),  4);
    check("stall_perr",   32'(perr1),   0);

    // Drain in FIFO order; the stalled 5th token follows the first four
    take1(3'd1);
    take1(3'd2);
    take1(3'd3);
    take1(3'd4);
    take1(3'd5);
    tick(8);
    check("drain_empty",  32'(empty1),  1);
    check("drain_count",  32'(count1),  0);
    check("drain_in_ack", 32'(in_ack1), 0);
    check("drain_perr",   32'(perr1),   0);

    // Protocol violation: refill, stall a toggle, then retract it unacked
    send1(3'd6);
    send1(3'd7);
    send1(3'd1);
    send1(3'd2);
    tick(6);
    check("viol_fill_count", 32'(count1), 4);
    in_req1 = ~in_req1;
    tick(2);
    check("viol_legal_stall", 32'(perr1), 0);
    in_req1 = ~in_req1;
    tick(2);
    check("viol_flag", 32'(perr1), 1);
    tick(5);
    check("viol_sticky", 32'(perr1), 1);
    rst_n1   = 1'b0;
    in_req1  = 1'b0;
    out_ack1 = 1'b0;
    tick(1);
    check("viol_rst_perr",  32'(perr1),  0);
    check("viol_rst_count", 32'(count1), 0);
    rst_n1 = 1'b1;
    tick(1);

    // Synchronised instance: two tokens in flight, then reset
    send2(3'd6);
    send2(3'd7);
    tick(1);
    rst_n2 = 1'b0;
    tick(1);
    check("srst_in_ack",   32'(in_ack2),   0);
    check("srst_out_req",  32'(out_req2),  0);
    check("srst_out_data", 32'(out_data2), 0);
    check("srst_count",    32'(count2),    0);
    check("srst_empty",    32'(empty2),    1);
    check("srst_full",     32'(full2),     0);
    check("srst_perr",     32'(perr2),     0);
    rst_n2 = 1'b1;
    tick(2);

    // Synchronised single token: ack after t+2, out_req after t+5
    in_data2 = 3'b011;
    in_req2  = 1'b1;
    tick(1);
    check("sync_ack_t",    32'(in_ack2), 0);
    tick(1);
    check("sync_ack_t1",   32'(in_ack2), 0);
    tick(1);
    check("sync_ack_t2",   32'(in_ack2),  1);
    check("sync_oreq_t2",  32'(out_req2), 0);
    tick(2);
    check("sync_oreq_t4",  32'(out_req2), 0);
    tick(1);
    check("sync_oreq_t5",  32'(out_req2),  1);
    check("sync_data_t5",  32'(out_data2), 3);
    check("sync_count_t5", 32'(count2),    1);
    out_ack2 = 1'b1;
    tick(1);
    check("sync_count_a1", 32'(count2), 1);
    tick(1);
    check("sync_count_a2", 32'(count2), 0);
    check("sync_empty_a2", 32'(empty2), 1);
    check("sync_perr",     32'(perr2),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
